// File: rtl/slurm32_icache_if.sv
//==============================================================
// slurm32_icache_if - fetch and line-fill bus of the icache, rev 1.0
//==============================================================
`default_nettype none

interface slurm32_icache_if;
  logic        instruction_request;
  logic [31:0] instruction_address;
  logic        instruction_valid;
  logic [31:0] instruction_in;
  logic        invalidate;
  logic        mem_request;
  logic [31:0] mem_address;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport slave (
    input  instruction_request, instruction_address, invalidate, mem_ready, mem_data,
    output instruction_valid, instruction_in, mem_request, mem_address
  );

  modport master (
    output instruction_request, instruction_address, invalidate, mem_ready, mem_data,
    input  instruction_valid, instruction_in, mem_request, mem_address
  );
endinterface

`default_nettype wire

// File: rtl/slurm32_icache.sv
//==============================================================
// slurm32_icache - direct-mapped instruction cache, 4-word lines, rev 1.0
//==============================================================
`default_nettype none

module slurm32_icache #(
  parameter int LINES = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  slurm32_icache_if.slave  bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  localparam logic [1:0] LOOKUP  = 2'd0;
  localparam logic [1:0] FILL    = 2'd1;
  localparam logic [1:0] REFETCH = 2'd2;

  logic [1:0]        r_state;
  logic [31:2]       r_addr;
  logic              r_pending;
  logic              r_force;
  logic              r_inv_seen;
  logic [31:0]       r_rdata;
  logic [1:0]        r_count;
  logic              r_mem_request;
  logic [31:0]       r_mem_address;
  logic [LINES-1:0]  r_valid;
  logic [31:0]       r_data_ram [LINES*4];
  logic [TAG_W-1:0]  r_tag_ram  [LINES];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W+1:0]  w_word;
  logic [IDX_W+1:0]  w_req_word;
  logic              w_hit;
  logic              w_miss;
  logic              w_last_beat;
  logic              w_unused_addr;

  assign w_idx         = r_addr[IDX_W+3:4];
  assign w_tag         = r_addr[31:IDX_W+4];
  assign w_word        = r_addr[IDX_W+3:2];
  assign w_req_word    = bus.instruction_address[IDX_W+3:2];
  assign w_unused_addr = ^bus.instruction_address[1:0];

  assign w_hit       = r_pending & r_valid[w_idx] & (r_tag_ram[w_idx] == w_tag);
  // r_force marks the single post-fill read, which must succeed even if the line was invalidated
  assign w_miss      = (r_state == LOOKUP) & r_pending & ~r_force & ~w_hit;
  assign w_last_beat = (r_state == FILL) & bus.mem_ready & (r_count == 2'd3);

  assign bus.instruction_valid = (r_state == LOOKUP) & r_pending & (r_force | w_hit);
  assign bus.instruction_in    = r_rdata;
  assign bus.mem_request       = r_mem_request;
  assign bus.mem_address       = r_mem_address;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= LOOKUP;
      r_addr        <= '0;
      r_pending     <= 1'b0;
      r_force       <= 1'b0;
      r_inv_seen    <= 1'b0;
      r_rdata       <= '0;
      r_count       <= 2'd0;
      r_mem_request <= 1'b0;
      r_mem_address <= '0;
      r_valid       <= '0;
    end else begin
      if (bus.invalidate) begin
        r_valid <= '0;
      end
      case (r_state)
        LOOKUP: begin
          r_force <= 1'b0;
          if (w_miss) begin
            r_state       <= FILL;
            r_mem_request <= 1'b1;
            r_mem_address <= {r_addr[31:4], 4'b0000};
            r_count       <= 2'd0;
            r_pending     <= 1'b0;
            r_inv_seen    <= 1'b0;
          end else begin
            r_pending <= bus.instruction_request;
            if (bus.instruction_request) begin
              r_addr  <= bus.instruction_address[31:2];
              r_rdata <= r_data_ram[w_req_word];
            end
          end
        end
        FILL: begin
          if (bus.invalidate) begin
            r_inv_seen <= 1'b1;
          end
          if (bus.mem_ready) begin
            r_count <= r_count + 2'd1;
          end
          if (w_last_beat) begin
            r_mem_request <= 1'b0;
            r_state       <= REFETCH;
            if (!bus.invalidate && !r_inv_seen) begin
              r_valid[w_idx] <= 1'b1;
            end
          end
        end
        REFETCH: begin
          r_rdata   <= r_data_ram[w_word];
          r_pending <= 1'b1;
          r_force   <= 1'b1;
          r_state   <= LOOKUP;
        end
        default: r_state <= LOOKUP;
      endcase
    end
  end

  // Line storage is not reset; r_valid alone decides whether its contents are usable
  always_ff @(posedge clk) begin
    if (r_state == FILL && bus.mem_ready) begin
      r_data_ram[{w_idx, r_count}] <= bus.mem_data;
    end
    if (w_last_beat) begin
      r_tag_ram[w_idx] <= w_tag;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_slurm32_icache.sv
//==============================================================
// tb_slurm32_icache - directed bench with a line-level cache model, rev 1.0
//==============================================================
`default_nettype none

module tb_slurm32_icache;
  logic clk;
  logic rst;
  slurm32_icache_if bus();

  slurm32_icache #(.LINES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  bit          mdl_valid [32];
  logic [22:0] mdl_tag   [32];

  bit          chk_en = 1'b0;
  bit          exp_valid;
  logic [31:0] exp_data;
  bit          exp_mreq;
  logic [31:0] exp_maddr;

  logic [31:0] last_maddr;
  logic [31:0] last_word;
  bit          last_missed;
  logic [31:0] sw0, sw1, sw2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:4] == 28'd0) return 32'h21010203 + {30'd0, w[3:2]} * 32'h00010101;
    return w ^ 32'hA5C30000;
  endfunction

  function automatic bit mdl_hit(input logic [31:0] a);
    return mdl_valid[a[8:4]] && (mdl_tag[a[8:4]] == a[31:9]);
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) mdl_valid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit v, input logic [31:0] d, input bit mr, input logic [31:0] ma);
    exp_valid = v;
    exp_data  = d;
    exp_mreq  = mr;
    exp_maddr = ma;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("instruction_valid", {31'd0, bus.instruction_valid}, {31'd0, exp_valid});
      if (exp_valid) check("instruction_in", bus.instruction_in, exp_data);
      check("mem_request", {31'd0, bus.mem_request}, {31'd0, exp_mreq});
      if (exp_mreq) check("mem_address", bus.mem_address, exp_maddr);
    end
  end

  // One full access; the current cycle is expected idle on entry and on return.
  task automatic fetch(input logic [31:0] a, input int stall_at = -1, input int stall_n = 0,
                       input int inv_beat = -1, input bit inv_accept = 1'b0, input int rst_beat = -1);
    logic [31:0] line;
    bit          line_inv;
    line = {a[31:4], 4'b0000};
    line_inv = 1'b0;
    bus.instruction_request = 1'b1;
    bus.instruction_address = a;
    bus.invalidate = inv_accept;
    if (inv_accept) mdl_clear();
    last_missed = !mdl_hit(a);
    step();
    bus.invalidate = 1'b0;
    if (!last_missed) begin
      set_exp(1'b1, mem_word(a), 1'b0, 32'd0);
      last_word = bus.instruction_in;
      bus.instruction_request = 1'b0;
      step();
      set_exp(1'b0, 32'd0, 1'b0, 32'd0);
      return;
    end
    set_exp(1'b0, 32'd0, 1'b0, 32'd0);
    step();
    set_exp(1'b0, 32'd0, 1'b1, line);
    last_maddr = bus.mem_address;
    for (int b = 0; b < 4; b++) begin
      if (b == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          bus.mem_ready = 1'b0;
          step();
          set_exp(1'b0, 32'd0, 1'b1, line);
        end
      end
      if (b == rst_beat) begin
        bus.instruction_request = 1'b0;
        bus.mem_ready = 1'b0;
        set_exp(1'b0, 32'd0, 1'b0, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_fill mem_request", {31'd0, bus.mem_request}, 32'd0);
        check("rst_mid_fill mem_address", bus.mem_address, 32'd0);
        check("rst_mid_fill instruction_valid", {31'd0, bus.instruction_valid}, 32'd0);
        check("rst_mid_fill instruction_in", bus.instruction_in, 32'd0);
        mdl_clear();
        step();
        rst = 1'b0;
        return;
      end
      bus.mem_ready = 1'b1;
      bus.mem_data  = mem_word(line + 32'(4 * b));
      if (b == inv_beat) begin
        bus.invalidate = 1'b1;
        line_inv = 1'b1;
        mdl_clear();
      end
      step();
      bus.invalidate = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.mem_data   = 32'd0;
      if (b < 3) set_exp(1'b0, 32'd0, 1'b1, line);
    end
    set_exp(1'b0, 32'd0, 1'b0, 32'd0);
    if (!line_inv) begin
      mdl_valid[a[8:4]] = 1'b1;
      mdl_tag[a[8:4]]   = a[31:9];
    end
    step();
    set_exp(1'b1, mem_word(a), 1'b0, 32'd0);
    last_word = bus.instruction_in;
    bus.instruction_request = 1'b0;
    step();
    set_exp(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic stream(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    bus.instruction_request = 1'b1;
    bus.instruction_address = a0;
    step();
    set_exp(mdl_hit(a0), mem_word(a0), 1'b0, 32'd0);
    sw0 = bus.instruction_in;
    bus.instruction_address = a1;
    step();
    set_exp(mdl_hit(a1), mem_word(a1), 1'b0, 32'd0);
    sw1 = bus.instruction_in;
    bus.instruction_address = a2;
    step();
    set_exp(mdl_hit(a2), mem_word(a2), 1'b0, 32'd0);
    sw2 = bus.instruction_in;
    bus.instruction_request = 1'b0;
    step();
    set_exp(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic pulse_invalidate();
    bus.invalidate = 1'b1;
    mdl_clear();
    step();
    bus.invalidate = 1'b0;
    set_exp(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.instruction_request = 1'b0;
    bus.instruction_address = 32'd0;
    bus.invalidate = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_data   = 32'd0;
    mdl_clear();
    set_exp(1'b0, 32'd0, 1'b0, 32'd0);
    step();
    step();
    check("reset instruction_valid", {31'd0, bus.instruction_valid}, 32'd0);
    check("reset instruction_in", bus.instruction_in, 32'd0);
    check("reset mem_request", {31'd0, bus.mem_request}, 32'd0);
    check("reset mem_address", bus.mem_address, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    fetch(32'h0000_0000);
    check("cold miss", {31'd0, last_missed}, 32'd1);
    check("cold fill address", last_maddr, 32'h0000_0000);
    check("cold word", last_word, 32'h2101_0203);

    stream(32'h4, 32'h8, 32'hC);
    check("stream word 0x4", sw0, 32'h2102_0304);
    check("stream word 0x8", sw1, 32'h2103_0405);
    check("stream word 0xC", sw2, 32'h2104_0506);
    step();

    fetch(32'h0000_0200);
    check("conflict miss", {31'd0, last_missed}, 32'd1);
    check("conflict fill address", last_maddr, 32'h0000_0200);
    check("conflict word", last_word, 32'hA5C3_0200);
    fetch(32'h0000_0000);
    check("evicted line misses", {31'd0, last_missed}, 32'd1);

    fetch(32'h0000_0018, 2, 3);
    check("stalled fill address", last_maddr, 32'h0000_0010);
    check("stalled word", last_word, 32'hA5C3_0018);
    fetch(32'h0000_0010);
    check("stalled line hit", {31'd0, last_missed}, 32'd0);

    pulse_invalidate();
    fetch(32'h0000_0000);
    check("post-invalidate miss", {31'd0, last_missed}, 32'd1);

    fetch(32'h0000_0030, -1, 0, 1);
    check("inv mid-fill word", last_word, 32'hA5C3_0030);
    fetch(32'h0000_0030);
    check("inv mid-fill then miss", {31'd0, last_missed}, 32'd1);
    fetch(32'h0000_0044, -1, 0, 3);
    fetch(32'h0000_0044);
    check("inv final beat then miss", {31'd0, last_missed}, 32'd1);

    fetch(32'h0000_0010);
    fetch(32'h0000_0010, -1, 0, -1, 1'b1);
    check("inv same-edge accept misses", {31'd0, last_missed}, 32'd1);

    fetch(32'h0000_0054, -1, 0, -1, 1'b0, 2);
    step();
    fetch(32'h0000_0054);
    check("after reset miss", {31'd0, last_missed}, 32'd1);
    check("after reset fill address", last_maddr, 32'h0000_0050);
    check("after reset word", last_word, 32'hA5C3_0054);
    step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/slurm32_icache.md
SLURM32_ICACHE -- requirements
Module: slurm32_icache

Interface
REQ-001 CLK  in  1  single clock; all state updates on rising edge.
REQ-002 RST  in  1  asynchronous, active-high reset.
REQ-003 instruction_request  in  1  pipeline is fetching; a lookup is issued on each edge where it is high.
REQ-004 instruction_address  in  32  byte address of the fetch; bits [1:0] are ignored.
REQ-005 instruction_valid  out  1  instruction_in holds the word for the last accepted address.
REQ-006 instruction_in  out  32  fetched instruction word.
REQ-007 invalidate  in  1  single-cycle pulse that clears every line's valid bit.
REQ-008 mem_request  out  1  line-fill request to the memory side, held high for the whole burst.
REQ-009 mem_address  out  32  line-aligned fill address, {tag, index, 4'b0000}.
REQ-010 mem_ready  in  1  one fill word is present on mem_data this cycle.
REQ-011 mem_data  in  32  fill data; words arrive in ascending order from offset 0.
REQ-012 Parameter LINES, default 32: number of direct-mapped lines, each 4 words (16 bytes).

Function
REQ-013 Address split (LINES=32): word offset is [3:2], index is [8:4], tag is [31:9].
REQ-014 The state machine SHALL have exactly three states: LOOKUP, FILL and REFETCH.
REQ-015 LOOKUP: on an edge with instruction_request=1, the block latches the address and reads the data RAM at index/offset synchronously; pending is set to 1.
REQ-016 Hit is defined as pending & valid[idx] & (tag[idx]==latched tag), evaluated in the cycle after the accept.
REQ-017 On a hit, instruction_valid=1 and instruction_in=the word in that cycle, giving 1-cycle latency.
REQ-018 Back-to-back hits SHALL sustain one instruction per cycle.
REQ-019 instruction_request=0 at an edge in LOOKUP clears pending, so instruction_valid=0 in the next cycle.
REQ-020 Miss: in the cycle pending=1 and the lookup misses, instruction_valid=0; the next edge enters FILL.
REQ-021 Entering FILL sets mem_request=1, drives mem_address with the latched line address, and clears word count to 0.
REQ-022 In FILL, each edge with mem_ready=1 writes mem_data to word[count] of the indexed line and increments count.
REQ-023 mem_ready=0 cycles in FILL SHALL be waited on indefinitely, with no timeout.
REQ-024 The edge carrying the 4th beat (count==3) writes the tag and sets the valid bit, clears mem_request, and enters REFETCH.
REQ-025 REFETCH lasts one cycle: it re-reads the RAM at the latched address, sets pending, and returns to LOOKUP.
REQ-026 After REFETCH, instruction_valid=1 with the missed word in the second cycle after the final mem_ready beat.
REQ-027 During FILL and REFETCH, instruction_request and instruction_address are ignored, and instruction_valid=0.
REQ-028 The pipeline holds its address while valid is low.
REQ-029 invalidate in LOOKUP clears all valid bits at that edge; a lookup accepted on the same edge sees the cleared state and misses.
REQ-030 invalidate during FILL or REFETCH (including the final-beat edge) lets the burst complete, but the filled line is left invalid.
REQ-031 The REFETCH that follows still returns the filled word once; subsequent accesses miss.
REQ-032 mem_address is stable while mem_request=1; mem_request never deasserts mid-burst.
REQ-033 instruction_in is don't-care when instruction_valid=0; the bench SHALL check it only when valid.

Reset
REQ-034 RST asserted (at any time, including mid-FILL) immediately sets state=LOOKUP, pending=0, instruction_valid=0, instruction_in=0, mem_request=0, mem_address=0, count=0 and all valid bits=0.
REQ-035 Data and tag RAM contents are not reset.
REQ-036 After RST deasserts, the first accepted request always misses.

Verification
REQ-037 Cold miss: after reset, request 0x00000000; memory returns 0x21010203, 0x21020304, 0x21030405, 0x21040506 with mem_ready high for 4 consecutive cycles. Required: mem_request=1 with mem_address=0x00000000, then valid=1 with instruction_in=0x21010203 two cycles after the last beat.
REQ-038 Streaming hits: following the cold miss, request 0x4, 0x8, 0xC on consecutive cycles. Required: valid=1 on 3 consecutive cycles with 0x21020304, 0x21030405 and 0x21040506, and mem_request stays 0.
REQ-039 Conflict eviction: request 0x200 (same index 0, different tag). Required: a miss with mem_address=0x00000200; then a request for 0x0 misses again.
REQ-040 Stalled fill: insert 3 mem_ready=0 cycles between beats 2 and 3. Required: mem_request is held, mem_address is unchanged, and the correct word is returned after the 4th beat.
REQ-041 Invalidate: pulse invalidate after line 0 is filled, then request 0x0. Required: a miss with a new burst; invalidate asserted mid-fill returns the word once, and the next request to the same line misses.
REQ-042 Reset mid-fill: assert RST after beat 2. Required: all outputs return to 0 immediately, and a subsequent request restarts the fill at offset 0.
